// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: multi-channel Gray encoder/decoder with a STAGES-deep valid/ready pipeline.
// Define GRAY_CODEC_ERRCHK_EN to add sticky per-channel single-step violation flags (err_flag/err_clear).
module gray_codec_pipe #(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 2,
    parameter int STAGES   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_mode,
    output logic [CHANNELS*WIDTH-1:0] out_data
`ifdef GRAY_CODEC_ERRCHK_EN
    ,
    output logic [CHANNELS-1:0]       err_flag,
    input  logic                      err_clear
`endif
);

    localparam int DW  = CHANNELS * WIDTH;
    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

    function automatic logic [WIDTH-1:0] gray_encode(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Resolves the Gray bits of segment k in place; every bit above the segment is already binary.
    function automatic logic [WIDTH-1:0] resolve_seg(input logic [WIDTH-1:0] w_in, input int k);
        logic [WIDTH-1:0] w;
        int hi;
        int lo;
        w  = w_in;
        hi = WIDTH - 1 - k * SEG;
        lo = WIDTH - (k + 1) * SEG;
        for (int n = WIDTH - 2; n >= 0; n--) begin
            if (n <= hi && n >= lo) begin
                w[n] = w[n] ^ w[n + 1];
            end
        end
        return w;
    endfunction

    logic              adv;
    logic [STAGES-1:0] valid_d, valid_q;
    logic [STAGES-1:0] mode_d, mode_q;
    logic [DW-1:0]     data_d [STAGES];
    logic [DW-1:0]     data_q [STAGES];

    always_comb begin
        adv     = ~valid_q[STAGES-1] | out_ready;
        valid_d = valid_q;
        mode_d  = mode_q;
        data_d  = data_q;
        if (adv) begin
            valid_d[0] = in_valid;
            mode_d[0]  = in_mode;
            for (int c = 0; c < CHANNELS; c++) begin
                data_d[0][c*WIDTH +: WIDTH] = in_mode ? gray_encode(in_data[c*WIDTH +: WIDTH])
                                                      : resolve_seg(in_data[c*WIDTH +: WIDTH], 0);
            end
            // Encoded beats are final after stage 0; later stages only delay them.
            for (int k = 1; k < STAGES; k++) begin
                valid_d[k] = valid_q[k-1];
                mode_d[k]  = mode_q[k-1];
                for (int c = 0; c < CHANNELS; c++) begin
                    data_d[k][c*WIDTH +: WIDTH] = mode_q[k-1] ? data_q[k-1][c*WIDTH +: WIDTH]
                                                              : resolve_seg(data_q[k-1][c*WIDTH +: WIDTH], k);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            mode_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];
    assign out_mode  = mode_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

`ifdef GRAY_CODEC_ERRCHK_EN
    logic [WIDTH-1:0]    last_d [CHANNELS];
    logic [WIDTH-1:0]    last_q [CHANNELS];
    logic [CHANNELS-1:0] has_prev_d, has_prev_q;
    logic [CHANNELS-1:0] err_d, err_q;

    // A set from a new violation overrides a clear in the same cycle.
    always_comb begin
        last_d     = last_q;
        has_prev_d = has_prev_q;
        err_d      = err_clear ? '0 : err_q;
        if (in_valid && adv && !in_mode) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (has_prev_q[c] && ($countones(in_data[c*WIDTH +: WIDTH] ^ last_q[c]) > 1)) begin
                    err_d[c] = 1'b1;
                end
                last_d[c]     = in_data[c*WIDTH +: WIDTH];
                has_prev_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            has_prev_q <= '0;
            err_q      <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                last_q[c] <= '0;
            end
        end else begin
            has_prev_q <= has_prev_d;
            err_q      <= err_d;
            for (int c = 0; c < CHANNELS; c++) begin
                last_q[c] <= last_d[c];
            end
        end
    end

    assign err_flag = err_q;
`endif

endmodule
